// File: rtl/fwd_hazard_ctrl_pkg.sv
// rtl/fwd_hazard_ctrl_pkg.sv - shared encodings, widths and stage record for the forwarding/hazard control
package fwd_hazard_ctrl_pkg;

  localparam int REG_W  = 16;
  localparam int ADDR_W = 5;

  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_EX = 2'b01;
  localparam logic [1:0] SEL_DM = 2'b10;
  localparam logic [1:0] SEL_WB = 2'b11;

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [ADDR_W-1:0] dst;
  } stage_t;

  function automatic logic stage_hit(input stage_t s, input logic [ADDR_W-1:0] r);
    return s.valid && s.wr && (s.dst == r);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// rtl/fwd_hazard_ctrl_if.sv - decode-side request and forwarding/stall response bundle
interface fwd_hazard_ctrl_if;
  import fwd_hazard_ctrl_pkg::*;

  logic              id_valid;
  logic [ADDR_W-1:0] RA;
  logic [ADDR_W-1:0] RB;
  logic              use_A;
  logic              use_B;
  logic [ADDR_W-1:0] RW_id;
  logic              wr_id;
  logic              ld_id;
  logic              flush;
  logic [1:0]        mux_sel_A;
  logic [1:0]        mux_sel_B;
  logic              stall;
  logic [ADDR_W-1:0] RW_dm;
  logic              wr_dm;
  logic [REG_W-1:0]  stall_cnt;

  modport master (
    output id_valid, RA, RB, use_A, use_B, RW_id, wr_id, ld_id, flush,
    input  mux_sel_A, mux_sel_B, stall, RW_dm, wr_dm, stall_cnt
  );

  modport slave (
    input  id_valid, RA, RB, use_A, use_B, RW_id, wr_id, ld_id, flush,
    output mux_sel_A, mux_sel_B, stall, RW_dm, wr_dm, stall_cnt
  );

endinterface

// File: rtl/fwd_hazard_ctrl_fwd_match.sv
// rtl/fwd_hazard_ctrl_fwd_match.sv - per-operand youngest-first forwarding comparator
module fwd_match
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic              en,
  input  logic [ADDR_W-1:0] src,
  input  stage_t            ex,
  input  stage_t            dm,
  input  stage_t            wb,
  output logic [1:0]        sel,
  output logic              ex_hit
);

  always_comb begin
    sel    = SEL_RF;
    ex_hit = en && stage_hit(ex, src);
    if (ex_hit)
      sel = SEL_EX;
    else if (en && stage_hit(dm, src))
      sel = SEL_DM;
    else if (en && stage_hit(wb, src))
      sel = SEL_WB;
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX/DM/WB destination tracking, operand forwarding selects and load-use stall
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  fwd_hazard_ctrl_if.slave   bus
);

  stage_t           ex_q, dm_q, wb_q;
  logic             ex_ld_q;
  logic             ex_hit_a, ex_hit_b;
  logic             stall;
  logic [REG_W-1:0] cnt_q;

  fwd_match u_match_a (
    .en     (bus.id_valid & bus.use_A),
    .src    (bus.RA),
    .ex     (ex_q),
    .dm     (dm_q),
    .wb     (wb_q),
    .sel    (bus.mux_sel_A),
    .ex_hit (ex_hit_a)
  );

  fwd_match u_match_b (
    .en     (bus.id_valid & bus.use_B),
    .src    (bus.RB),
    .ex     (ex_q),
    .dm     (dm_q),
    .wb     (wb_q),
    .sel    (bus.mux_sel_B),
    .ex_hit (ex_hit_b)
  );

  // A load in EX has no result yet; a flushed consumer never needs to wait for it.
  assign stall = bus.id_valid & ex_ld_q & (ex_hit_a | ex_hit_b) & ~bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      dm_q    <= '0;
      wb_q    <= '0;
      ex_ld_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      dm_q <= ex_q;
      wb_q <= dm_q;
      if (!stall && !bus.flush) begin
        ex_q    <= '{valid: bus.id_valid, wr: bus.wr_id, dst: bus.RW_id};
        ex_ld_q <= bus.id_valid & bus.ld_id;
      end else begin
        ex_q    <= '0;
        ex_ld_q <= 1'b0;
      end
      if (stall && (cnt_q != {REG_W{1'b1}}))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.stall     = stall;
  assign bus.RW_dm     = dm_q.dst;
  assign bus.wr_dm     = dm_q.valid & dm_q.wr;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - directed vector table, hand sequences and randomized model check
module tb_fwd_hazard_ctrl;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [4:0] ra;
    logic [4:0] rb;
    logic       ua;
    logic       ub;
    logic [4:0] rw;
    logic       wr;
    logic       ld;
    logic       fl;
  } in_t;

  typedef struct {
    in_t        i;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       st;
    logic       wdm;
    int         cnt;
  } vec_t;

  typedef struct {
    logic       v;
    logic       w;
    logic       l;
    logic [4:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  // hist[0] is the instruction in EX, hist[1] in DM, hist[2] in WB
  ent_t hist [3];
  int   m_cnt;

  fwd_hazard_ctrl_if bus ();

  fwd_hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic in_t mk(input logic iv, input int ra, input int rb, input logic ua,
                             input logic ub, input int rw, input logic wr, input logic ld,
                             input logic fl);
    in_t x;
    x.rst = 1'b0; x.iv = iv; x.ra = 5'(ra); x.rb = 5'(rb); x.ua = ua; x.ub = ub;
    x.rw = 5'(rw); x.wr = wr; x.ld = ld; x.fl = fl;
    return x;
  endfunction

  function automatic in_t idle();          return mk(0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic in_t nop();           return mk(1, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic in_t alu_wr(int r);   return mk(1, 0, 0, 0, 0, r, 1, 0, 0); endfunction
  function automatic in_t ld_wr(int r);    return mk(1, 0, 0, 0, 0, r, 1, 1, 0); endfunction
  function automatic in_t rd_a(int r);     return mk(1, r, 0, 1, 0, 0, 0, 0, 0); endfunction
  function automatic in_t rd_b(int r);     return mk(1, 0, r, 0, 1, 0, 0, 0, 0); endfunction

  function automatic vec_t mkv(input in_t i, input int sa, input int sb, input logic st,
                               input logic wdm, input int cnt);
    vec_t v;
    v.i = i; v.sa = 2'(sa); v.sb = 2'(sb); v.st = st; v.wdm = wdm; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input in_t x);
    rst          = x.rst;
    bus.id_valid = x.iv;
    bus.RA       = x.ra;
    bus.RB       = x.rb;
    bus.use_A    = x.ua;
    bus.use_B    = x.ub;
    bus.RW_id    = x.rw;
    bus.wr_id    = x.wr;
    bus.ld_id    = x.ld;
    bus.flush    = x.fl;
  endtask

  function automatic int m_sel(input in_t x, input logic use_r, input logic [4:0] r);
    if (!use_r || !x.iv) return 0;
    for (int k = 0; k < 3; k++)
      if (hist[k].v && hist[k].w && hist[k].d == r) return k + 1;
    return 0;
  endfunction

  function automatic logic m_stall(input in_t x);
    logic ex_load;
    ex_load = hist[0].v && hist[0].w && hist[0].l;
    return x.iv && !x.fl && ex_load &&
           ((x.ua && hist[0].d == x.ra) || (x.ub && hist[0].d == x.rb));
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 3; k++) hist[k] = '{v: 0, w: 0, l: 0, d: 0};
    m_cnt = 0;
  endtask

  task automatic m_edge(input in_t x);
    logic st;
    st = m_stall(x);
    if (x.rst) begin
      m_reset();
    end else begin
      if (st && m_cnt < 65535) m_cnt++;
      hist[2] = hist[1];
      hist[1] = hist[0];
      if (!st && !x.fl) hist[0] = '{v: x.iv, w: x.wr, l: x.ld, d: x.rw};
      else              hist[0] = '{v: 0, w: 0, l: 0, d: 0};
    end
  endtask

  task automatic tick(input in_t x);
    m_edge(x);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [$];
  in_t  x;

  initial begin
    tbl.push_back(mkv(idle(),      0, 0, 0, 0, 0));
    tbl.push_back(mkv(alu_wr(3),   0, 0, 0, 0, 0));
    tbl.push_back(mkv(rd_a(3),     1, 0, 0, 0, 0));
    tbl.push_back(mkv(alu_wr(5),   0, 0, 0, 1, 0));
    tbl.push_back(mkv(alu_wr(9),   0, 0, 0, 0, 0));
    tbl.push_back(mkv(rd_b(5),     0, 2, 0, 1, 0));
    tbl.push_back(mkv(alu_wr(5),   0, 0, 0, 1, 0));
    tbl.push_back(mkv(alu_wr(9),   0, 0, 0, 0, 0));
    tbl.push_back(mkv(nop(),       0, 0, 0, 1, 0));
    tbl.push_back(mkv(rd_b(5),     0, 3, 0, 1, 0));
    tbl.push_back(mkv(alu_wr(5),   0, 0, 0, 0, 0));
    tbl.push_back(mkv(nop(),       0, 0, 0, 0, 0));
    tbl.push_back(mkv(nop(),       0, 0, 0, 1, 0));
    tbl.push_back(mkv(nop(),       0, 0, 0, 0, 0));
    tbl.push_back(mkv(rd_b(5),     0, 0, 0, 0, 0));
    tbl.push_back(mkv(ld_wr(7),    0, 0, 0, 0, 0));
    tbl.push_back(mkv(rd_a(7),     1, 0, 1, 0, 0));
    tbl.push_back(mkv(rd_a(7),     2, 0, 0, 1, 1));
    tbl.push_back(mkv(ld_wr(7),    0, 0, 0, 0, 1));
    tbl.push_back(mkv(mk(1, 7, 0, 1, 0, 12, 1, 0, 1), 1, 0, 0, 0, 1));
    tbl.push_back(mkv(idle(),      0, 0, 0, 1, 1));
    tbl.push_back(mkv(mk(1, 12, 7, 1, 1, 0, 0, 0, 0), 0, 3, 0, 0, 1));
    tbl.push_back(mkv(alu_wr(2),   0, 0, 0, 0, 1));
    tbl.push_back(mkv(nop(),       0, 0, 0, 0, 1));
    tbl.push_back(mkv(alu_wr(2),   0, 0, 0, 1, 1));
    tbl.push_back(mkv(mk(1, 2, 2, 1, 1, 0, 0, 0, 0), 1, 1, 0, 0, 1));
    tbl.push_back(mkv(alu_wr(0),   0, 0, 0, 1, 1));
    tbl.push_back(mkv(rd_a(0),     1, 0, 0, 0, 1));

    // reset state
    x = idle();
    x.rst = 1'b1;
    drive(x);
    @(posedge clk);
    #1;
    tick(x);
    x = idle();
    drive(x);
    @(negedge clk);
    chk("reset_sel_a", 0, int'(bus.mux_sel_A), 0);
    chk("reset_sel_b", 0, int'(bus.mux_sel_B), 0);
    chk("reset_stall", 0, int'(bus.stall), 0);
    chk("reset_wr_dm", 0, int'(bus.wr_dm), 0);
    chk("reset_rw_dm", 0, int'(bus.RW_dm), 0);
    chk("reset_cnt",   0, int'(bus.stall_cnt), 0);
    @(posedge clk);
    #1;
    m_reset();
    x.rst = 1'b1;
    drive(x);
    tick(x);

    // directed table
    foreach (tbl[n]) begin
      drive(tbl[n].i);
      @(negedge clk);
      chk("tbl_sel_a", n, int'(bus.mux_sel_A), int'(tbl[n].sa));
      chk("tbl_sel_b", n, int'(bus.mux_sel_B), int'(tbl[n].sb));
      chk("tbl_stall", n, int'(bus.stall),     int'(tbl[n].st));
      chk("tbl_wr_dm", n, int'(bus.wr_dm),     int'(tbl[n].wdm));
      chk("tbl_cnt",   n, int'(bus.stall_cnt), tbl[n].cnt);
      tick(tbl[n].i);
    end

    // reset during a load-use stall
    x = ld_wr(7);
    drive(x);
    tick(x);
    x = rd_a(7);
    drive(x);
    @(negedge clk);
    chk("rst_mid_stall_pre", 0, int'(bus.stall), 1);
    tick(x);
    x.rst = 1'b1;
    drive(x);
    @(negedge clk);
    tick(x);
    x.rst = 1'b0;
    drive(x);
    @(negedge clk);
    chk("rst_mid_stall_stall", 1, int'(bus.stall), 0);
    chk("rst_mid_stall_sel_a", 1, int'(bus.mux_sel_A), 0);
    chk("rst_mid_stall_sel_b", 1, int'(bus.mux_sel_B), 0);
    chk("rst_mid_stall_cnt",   1, int'(bus.stall_cnt), 0);
    chk("rst_mid_stall_wr_dm", 1, int'(bus.wr_dm), 0);
    tick(x);

    // randomized traffic against the reference model
    for (int n = 0; n < 800; n++) begin
      x.rst = ($urandom_range(0, 63) == 0);
      x.iv  = ($urandom_range(0, 7) != 0);
      x.ra  = 5'($urandom_range(0, 3));
      x.rb  = 5'($urandom_range(0, 3));
      x.ua  = 1'($urandom_range(0, 1));
      x.ub  = 1'($urandom_range(0, 1));
      x.rw  = 5'($urandom_range(0, 3));
      x.wr  = ($urandom_range(0, 3) != 0);
      x.ld  = ($urandom_range(0, 2) == 0);
      x.fl  = ($urandom_range(0, 15) == 0);
      drive(x);
      @(negedge clk);
      chk("rnd_sel_a", n, int'(bus.mux_sel_A), m_sel(x, x.ua, x.ra));
      chk("rnd_sel_b", n, int'(bus.mux_sel_B), m_sel(x, x.ub, x.rb));
      chk("rnd_stall", n, int'(bus.stall),     int'(m_stall(x)));
      chk("rnd_wr_dm", n, int'(bus.wr_dm),     int'(hist[1].v && hist[1].w));
      chk("rnd_cnt",   n, int'(bus.stall_cnt), m_cnt);
      if (hist[1].v && hist[1].w)
        chk("rnd_rw_dm", n, int'(bus.RW_dm), int'(hist[1].d));
      tick(x);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 clk  input  1  Single clock; all state updates on the rising edge.
REQ-002 rst  input  1  Reset, synchronous, active-high.
REQ-003 id_valid  input  1  Decode-stage instruction present.
REQ-004 RA  input  5  Decode-stage source register A.
REQ-005 RB  input  5  Decode-stage source register B.
REQ-006 use_A, use_B  input  1 each  Decode instruction reads RA / RB.
REQ-007 RW_id  input  5  Decode-stage destination register.
REQ-008 wr_id  input  1  Decode instruction writes RW_id.
REQ-009 ld_id  input  1  Decode instruction is a load; its result is available at DM, not EX.
REQ-010 flush  input  1  Discard the decode instruction; insert a bubble into EX.
REQ-011 mux_sel_A, mux_sel_B  output  2 each  Operand select to registerbank: 00 regfile, 01 ans_ex, 10 ans_dm, 11 ans_wb.
REQ-012 stall  output  1  Hold PC and the IF/ID stage this cycle.
REQ-013 RW_dm  output  5  Destination register of the instruction in DM; this is the registerbank write address.
REQ-014 wr_dm  output  1  DM-stage instruction is valid and writes.
REQ-015 stall_cnt  output  16  Count of stall cycles since reset, saturating.

Function
REQ-016 Tracking state: per stage EX, DM, WB, hold a valid bit, a 5-bit destination and a write flag; EX additionally holds a load flag.
REQ-017 Advance on each edge: DM<-EX and WB<-DM, without exception.
REQ-018 EX loads {id_valid & wr_id, RW_id, ld_id} when stall=0 and flush=0; otherwise EX becomes a bubble (valid=0).
REQ-019 Match rule, operand X in {A, B}: stage S matches when use_X=1, S is valid, S writes, and S destination equals RX.
REQ-020 mux_sel_X is combinational in the same cycle and uses youngest-first priority: EX match gives 01, else DM match gives 10, else WB match gives 11, else 00.
REQ-021 If use_X=0 or id_valid=0, mux_sel_X shall be 00.
REQ-022 Load-use: stall=1 when id_valid=1, the EX stage holds a valid writing load, and that load matches A or B under REQ-019.
REQ-023 Load-use stall lasts exactly one cycle. On the next cycle the load is in DM and the match selects 10 (ans_dm).
REQ-024 During stall, mux_sel outputs are don't-care to the datapath but shall still follow REQ-020.
REQ-025 flush=1 forces stall=0 in the same cycle, and the decode instruction never enters EX.
REQ-026 A single instruction may match on both A and B (RA==RB); both selects are then identical.
REQ-027 stall_cnt increments on each edge where stall=1 and rst=0, and saturates at 16'hFFFF.
REQ-028 No register is hardwired; register 0 is forwarded like any other.

Reset
REQ-029 When rst=1 at an edge, all stage valid bits, write flags and load flags clear, destinations clear to 0, and stall_cnt clears to 0.
REQ-030 After reset, with no new instructions: mux_sel_A=mux_sel_B=00, stall=0, wr_dm=0, RW_dm=0.
REQ-031 rst asserted mid-stall takes priority: the next cycle shows stall=0 and an empty pipeline.

Structure
REQ-032 A shared package holds the select encodings (SEL_RF=00, SEL_EX=01, SEL_DM=10, SEL_WB=11) and the width constants (REG_W=16, ADDR_W=5).
REQ-033 One sub-module, fwd_match, is natural: the per-operand priority comparator, instantiated for A and B.

Verification
REQ-034 Write R3 (ALU), then immediately an instruction reading RA=3 -> mux_sel_A=01 in the second cycle, stall=0.
REQ-035 Write R5; one independent instruction; then read RB=5 -> mux_sel_B=10. With two intervening instructions -> 11. With three -> 00.
REQ-036 Load R7, then immediately read RA=7 -> stall=1 for one cycle, stall_cnt=1. Next cycle mux_sel_A=10, stall=0.
REQ-037 Load R7 followed by an instruction reading R7 with flush=1 -> stall=0 and stall_cnt unchanged. The EX bubble produces no later forwarding for that instruction.
REQ-038 ALU write R2 in WB and ALU write R2 in EX, then read R2 on both A and B -> mux_sel_A=mux_sel_B=01 (youngest wins).
REQ-039 Assert rst during a load-use stall -> the next cycle shows stall=0, selects 00, stall_cnt=0, wr_dm=0.
